// File: rtl/e3_pkg.sv
// Shared constants, FSM encoding and digit helpers for the Excess-3 divider.
// E3_DIV_CHECK_EN adds a digit-code validity check in LOAD.
package e3_pkg;

    localparam logic [3:0] E3_ZERO   = 4'b0011;
    localparam logic [3:0] E3_NINE   = 4'b1100;
    localparam logic [3:0] E3_OFFSET = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SUB  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [3:0] e3_to_bin(input logic [3:0] e);
        return e - E3_OFFSET;
    endfunction

    function automatic logic e3_valid(input logic [3:0] e);
        return (e >= E3_ZERO) && (e <= E3_NINE);
    endfunction

endpackage

// File: rtl/e3_div_if.sv
// start/done request bundle between the controller and the E3 divider.
// No configuration macros are used in this file.
interface e3_div_if;

    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, err
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, err
    );

endinterface

// File: rtl/e3_digit_inc.sv
// Enabled Excess-3 digit incrementer; 1100 wraps to 0011 with carry.
// No configuration macros are used in this file.
module e3_digit_inc
    import e3_pkg::*;
(
    input  logic [3:0] in_i,
    input  logic       en_i,
    output logic [3:0] out_o,
    output logic       carry_o
);

    logic at_nine;

    assign at_nine = (in_i == E3_NINE);
    assign carry_o = en_i && at_nine;

    always_comb begin
        out_o = in_i;
        if (en_i) begin
            out_o = at_nine ? E3_ZERO : in_i + 4'd1;
        end
    end

endmodule

// File: rtl/e3_div.sv
// Sequential E3 divider: two-digit dividend / one-digit divisor by repeated subtraction.
// Define E3_DIV_CHECK_EN to flag invalid digit codes through err.
module e3_div
    import e3_pkg::*;
(
    input  logic    clk,
    input  logic    rst_b,
    e3_div_if.slave bus
);

    state_t     state_q, state_d;
    logic [7:0] dvd_q, dvd_d;
    logic [3:0] dvs_q, dvs_d;
    logic [6:0] rem_q, rem_d;
    logic [3:0] d_q, d_d;
    logic       bad_q, bad_d;
    logic [7:0] quot_q, quot_d;
    logic [3:0] rmd_q, rmd_d;
    logic       err_q, err_d;

    logic [3:0] tens_b, units_b, dvs_b;
    logic [3:0] units_inc, tens_inc;
    logic       units_cy, tens_cy;
    logic       load_bad;
    logic [6:0] d_ext;

    assign tens_b  = e3_to_bin(dvd_q[7:4]);
    assign units_b = e3_to_bin(dvd_q[3:0]);
    assign dvs_b   = e3_to_bin(dvs_q);
    assign d_ext   = {3'b000, d_q};

`ifdef E3_DIV_CHECK_EN
    assign load_bad = (dvs_b == 4'd0)
                   || !e3_valid(dvd_q[7:4])
                   || !e3_valid(dvd_q[3:0])
                   || !e3_valid(dvs_q);
`else
    assign load_bad = (dvs_b == 4'd0);
`endif

    e3_digit_inc u_units (
        .in_i    (quot_q[3:0]),
        .en_i    (1'b1),
        .out_o   (units_inc),
        .carry_o (units_cy)
    );

    e3_digit_inc u_tens (
        .in_i    (quot_q[7:4]),
        .en_i    (units_cy),
        .out_o   (tens_inc),
        .carry_o (tens_cy)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            d_q     <= '0;
            bad_q   <= 1'b0;
            quot_q  <= {E3_ZERO, E3_ZERO};
            rmd_q   <= E3_ZERO;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            d_q     <= d_d;
            bad_q   <= bad_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            err_q   <= err_d;
        end
    end

    // Bad operands still pass through SUB so err and ok results share timing.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        d_d     = d_q;
        bad_d   = bad_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    err_d   = 1'b0;
                    quot_d  = {E3_ZERO, E3_ZERO};
                end
            end
            S_LOAD: begin
                rem_d   = 7'(tens_b) * 7'd10 + 7'(units_b);
                d_d     = dvs_b;
                bad_d   = load_bad;
                state_d = S_SUB;
            end
            S_SUB: begin
                if (bad_q) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    quot_d  = {E3_ZERO, E3_ZERO};
                    rmd_d   = E3_ZERO;
                end else if (rem_q >= d_ext) begin
                    rem_d  = rem_q - d_ext;
                    quot_d = {tens_inc, units_inc};
                end else begin
                    state_d = S_DONE;
                    rmd_d   = rem_q[3:0] + E3_OFFSET;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.quotient  = quot_q;
    assign bus.remainder = rmd_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q == S_LOAD) || (state_q == S_SUB);
    assign bus.done      = (state_q == S_DONE);

    logic unused_ok;
    assign unused_ok = tens_cy;

endmodule
